// File: rtl/fft_stp_collector.sv
// fft_stp_collector: serial-to-parallel frame collector feeding the FFT input stage.
// Shifts serial_in MSB first into NUM_WORDS words of WORD_WIDTH bits. It presents each
// completed frame on a registered parallel bus with a valid/ack handshake.
// Optional feature macro: STP_OVERRUN_DETECT_EN (sticky overrun flag when an unconsumed
// frame is overwritten). When the macro is undefined, overrun is tied to 0.
module fft_stp_collector #(
    parameter int unsigned WORD_WIDTH = 32,
    parameter int unsigned NUM_WORDS  = 16
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            serial_in,
    input  logic                            shift_enable,
    input  logic                            clear,
    input  logic                            frame_ack,
    output logic [NUM_WORDS*WORD_WIDTH-1:0] parallel_out,
    output logic                            frame_valid,
    output logic                            busy,
    output logic                            overrun
);

    localparam int unsigned FRAME_W = NUM_WORDS * WORD_WIDTH;
    localparam int unsigned BIT_CW  = (WORD_WIDTH > 1) ? $clog2(WORD_WIDTH) : 1;
    localparam int unsigned WORD_CW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    localparam logic [BIT_CW-1:0]  BIT_LAST  = BIT_CW'(WORD_WIDTH - 1);
    localparam logic [WORD_CW-1:0] WORD_LAST = WORD_CW'(NUM_WORDS - 1);

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    state_t               state, state_nxt;
    logic [BIT_CW-1:0]    bit_cnt, bit_cnt_nxt;
    logic [WORD_CW-1:0]   word_cnt, word_cnt_nxt;
    logic [FRAME_W-1:0]   shift_reg, shift_nxt;
    logic                 complete_c;

    // Next-state, counter and shift-register update; clear beats shift_enable
    always_comb begin
        state_nxt    = state;
        bit_cnt_nxt  = bit_cnt;
        word_cnt_nxt = word_cnt;
        shift_nxt    = shift_reg;
        complete_c   = 1'b0;

        if (clear) begin
            bit_cnt_nxt  = '0;
            word_cnt_nxt = '0;
            state_nxt    = IDLE;
        end else if (shift_enable) begin
            shift_nxt = {shift_reg[FRAME_W-2:0], serial_in};
            if (bit_cnt == BIT_LAST) begin
                bit_cnt_nxt = '0;
                if (word_cnt == WORD_LAST) begin
                    word_cnt_nxt = '0;
                    state_nxt    = IDLE;
                    complete_c   = 1'b1;
                end else begin
                    word_cnt_nxt = word_cnt + WORD_CW'(1);
                    state_nxt    = RECV;
                end
            end else begin
                bit_cnt_nxt = bit_cnt + BIT_CW'(1);
                state_nxt   = RECV;
            end
        end
    end

    // State, counters and shift register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            word_cnt  <= '0;
            shift_reg <= '0;
        end else begin
            state     <= state_nxt;
            bit_cnt   <= bit_cnt_nxt;
            word_cnt  <= word_cnt_nxt;
            shift_reg <= shift_nxt;
        end
    end

    // Registered busy tracks the state register exactly
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= 1'b0;
        end else begin
            busy <= (state_nxt == RECV);
        end
    end

    // Frame capture and handshake; a completion outranks a coincident ack
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parallel_out <= '0;
            frame_valid  <= 1'b0;
        end else begin
            if (complete_c) begin
                parallel_out <= shift_nxt;
                frame_valid  <= 1'b1;
            end else if (frame_ack) begin
                frame_valid  <= 1'b0;
            end
        end
    end

`ifdef STP_OVERRUN_DETECT_EN
    // Sticky flag: a new frame landed on top of one the consumer never took
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overrun <= 1'b0;
        end else if (clear) begin
            overrun <= 1'b0;
        end else if (complete_c && frame_valid && !frame_ack) begin
            overrun <= 1'b1;
        end
    end
`else
    assign overrun = 1'b0;
`endif

endmodule

// File: tb/tb_fft_stp_collector.sv
// Scoreboard bench for fft_stp_collector (W=32, N=16). The driver pushes each expected frame,
// and a monitor pops and compares it whenever the DUT presents a new frame.
module tb_fft_stp_collector;

    localparam int unsigned W  = 32;
    localparam int unsigned N  = 16;
    localparam int unsigned FW = W * N;

`ifdef STP_OVERRUN_DETECT_EN
    localparam logic EXP_OVR = 1'b1;
`else
    localparam logic EXP_OVR = 1'b0;
`endif

    logic          clk;
    logic          rst;
    logic          serial_in;
    logic          shift_enable;
    logic          clear;
    logic          frame_ack;
    logic [FW-1:0] parallel_out;
    logic          frame_valid;
    logic          busy;
    logic          overrun;

    int n_cmp = 0;
    int n_err = 0;
    logic [FW-1:0] exp_q[$];

    fft_stp_collector #(.WORD_WIDTH(W), .NUM_WORDS(N)) dut (
        .clk          (clk),
        .rst          (rst),
        .serial_in    (serial_in),
        .shift_enable (shift_enable),
        .clear        (clear),
        .frame_ack    (frame_ack),
        .parallel_out (parallel_out),
        .frame_valid  (frame_valid),
        .busy         (busy),
        .overrun      (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [FW-1:0] act, input logic [FW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [FW-1:0] frame_of(input logic [31:0] base);
        logic [FW-1:0] f;
        f = '0;
        for (int k = 0; k < int'(N); k++) begin
            f[FW-1-k*W -: W] = 32'(base + 32'(k));
        end
        return f;
    endfunction

    // Stream nbits of the frame built from base; optional gaps, ack on the last bit, busy checks
    task automatic send_frame(input logic [31:0] base, input int gap, input int nbits,
                              input bit ack_last, input bit chk_busy);
        logic [31:0] word;
        if (nbits == int'(FW)) exp_q.push_back(frame_of(base));
        for (int i = 0; i < nbits; i++) begin
            word         = 32'(base + 32'(i / 32));
            serial_in    = word[31 - (i % 32)];
            shift_enable = 1'b1;
            if (ack_last && i == int'(FW) - 1) frame_ack = 1'b1;
            @(negedge clk);
            shift_enable = 1'b0;
            frame_ack    = 1'b0;
            if (i == int'(FW) - 1) begin
                chk("valid_latency", FW'(frame_valid), FW'(1'b1));
                chk("busy_after_done", FW'(busy), FW'(1'b0));
            end else if (chk_busy && (i % 32) == 0) begin
                chk("busy_mid_frame", FW'(busy), FW'(1'b1));
            end
            repeat (gap) @(negedge clk);
        end
    endtask

    task automatic pulse_ack();
        frame_ack = 1'b1;
        @(negedge clk);
        frame_ack = 1'b0;
    endtask

    // Monitor: a new frame is valid rising, or fresh data while valid stays high
    logic          prev_fv;
    logic [FW-1:0] prev_po;
    initial begin
        prev_fv = 1'b0;
        prev_po = '0;
    end
    always @(negedge clk) begin
        if (rst) begin
            prev_fv = 1'b0;
        end else begin
            if (frame_valid && (!prev_fv || parallel_out != prev_po)) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_frame", FW'(1'b1), FW'(1'b0));
                end else begin
                    chk("frame_data", parallel_out, exp_q.pop_front());
                end
            end
            prev_fv = frame_valid;
        end
        prev_po = parallel_out;
    end

    initial begin
        rst = 1'b1; serial_in = 1'b0; shift_enable = 1'b0; clear = 1'b0; frame_ack = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_parallel_out", parallel_out, '0);
        chk("rst_frame_valid", FW'(frame_valid), '0);
        chk("rst_busy", FW'(busy), '0);
        chk("rst_overrun", FW'(overrun), '0);

        // Single continuous frame
        send_frame(32'hA5A50000, 0, FW, 1'b0, 1'b1);
        chk("first_word_msbs", FW'(parallel_out[FW-1 -: 32]), FW'(32'hA5A50000));
        chk("last_word_lsbs", FW'(parallel_out[31:0]), FW'(32'hA5A5000F));

        // Ack three cycles after valid rose
        repeat (2) @(negedge clk);
        pulse_ack();
        chk("ack_clears_valid", FW'(frame_valid), '0);
        chk("ack_keeps_data", parallel_out, frame_of(32'hA5A50000));

        // Gapped 1-on/2-off stream
        send_frame(32'hA5A50000, 2, FW, 1'b0, 1'b1);

        // Ack coincident with the next completion: valid stays high with new data
        send_frame(32'h12340000, 0, FW, 1'b1, 1'b0);
        @(negedge clk);
        chk("coincident_ack_valid", FW'(frame_valid), FW'(1'b1));
        chk("coincident_no_overrun", FW'(overrun), '0);
        pulse_ack();
        chk("ack2_clears_valid", FW'(frame_valid), '0);

        // Clear with shift_enable after 40 bits
        send_frame(32'hDEAD0000, 0, 40, 1'b0, 1'b0);
        serial_in = 1'b1; shift_enable = 1'b1; clear = 1'b1;
        @(negedge clk);
        shift_enable = 1'b0; clear = 1'b0;
        chk("clear_busy", FW'(busy), '0);
        chk("clear_keeps_data", parallel_out, frame_of(32'h12340000));
        chk("clear_keeps_valid", FW'(frame_valid), '0);
        send_frame(32'h0F0F0000, 0, FW, 1'b0, 1'b1);

        // Async reset after 100 bits of a frame
        send_frame(32'h77770000, 0, 100, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("midrst_parallel_out", parallel_out, '0);
        chk("midrst_frame_valid", FW'(frame_valid), '0);
        chk("midrst_busy", FW'(busy), '0);
        chk("midrst_overrun", FW'(overrun), '0);
        @(negedge clk);
        rst = 1'b0;
        send_frame(32'h5A5A0000, 0, FW, 1'b0, 1'b1);
        pulse_ack();

        // Two frames back-to-back, no ack
        send_frame(32'h11110000, 0, FW, 1'b0, 1'b0);
        chk("ovr_after_first", FW'(overrun), '0);
        send_frame(32'h22220000, 0, FW, 1'b0, 1'b0);
        chk("ovr_after_second", FW'(overrun), FW'(EXP_OVR));
        chk("ovr_holds_frame2", parallel_out, frame_of(32'h22220000));
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        chk("ovr_cleared", FW'(overrun), '0);
        chk("ovr_clear_keeps_valid", FW'(frame_valid), FW'(1'b1));

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", FW'(exp_q.size()), '0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
